pio_ctrl: RTL

Control sequencer between the host register interface and the four PIO state machines. It accepts host commands over a valid/ready handshake and applies them to the machines:
- enable-mask updates;
- synchronous restart pulses;
- clock-divider phase resets;
- forced (immediate) instruction injection, held until the target machine's divided clock enable consumes it.

One command executes at a time. Commands are processed in arrival order.

---
 rtl/pio_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pio_ctrl.sv
// rtl/pio_ctrl.sv - host command sequencer for the four PIO state machines (optional watchdog: PIO_CTRL_TIMEOUT_EN)
module pio_ctrl #(
  parameter int NUM_SM  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [NUM_SM-1:0] cmd_mask,
  input  logic [15:0]       cmd_data,
  input  logic [NUM_SM-1:0] sm_tick,
  output logic [NUM_SM-1:0] en,
  output logic [NUM_SM-1:0] restart,
  output logic [NUM_SM-1:0] div_restart,
  output logic [NUM_SM-1:0] imm,
  output logic [15:0]       imm_instr,
  output logic              busy,
  output logic              exec_err
);

  typedef enum logic [1:0] {
    OP_SET_EN   = 2'd0,
    OP_RESTART  = 2'd1,
    OP_EXEC     = 2'd2,
    OP_DIV_SYNC = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PULSE     = 2'd1,
    S_EXEC_WAIT = 2'd2,
    S_EXEC_DONE = 2'd3
  } state_t;

  localparam logic [NUM_SM-1:0] ONE = {{(NUM_SM-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_d;
  op_t               cmd_op_e;
  op_t               op_q;
  logic [NUM_SM-1:0] mask_q;
  logic [NUM_SM-1:0] tgt_q;
  logic [15:0]       data_q;
  logic [NUM_SM-1:0] cmd_lowest;
  logic              accept;
  logic              consume;
  logic              wd_fire;

  assign cmd_op_e   = op_t'(cmd_op);
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = cmd_valid && cmd_ready;

  // Two's-complement trick isolates the lowest set mask bit: that machine is the EXEC target.
  assign cmd_lowest = cmd_mask & (~cmd_mask + ONE);

  // The instruction is consumed only on a divided-clock tick of an enabled target.
  assign consume    = (state == S_EXEC_WAIT) && (|(tgt_q & sm_tick & en));

`ifdef PIO_CTRL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  assign wd_fire  = (state == S_EXEC_WAIT) && !consume && (wd_cnt == 8'(TIMEOUT - 1));
  assign exec_err = err_q;

  // Watchdog counts cycles spent in EXEC_WAIT, cleared everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= 8'd0;
    end else if (state == S_EXEC_WAIT) begin
      wd_cnt <= wd_cnt + 8'd1;
    end else begin
      wd_cnt <= 8'd0;
    end
  end

  // Sticky error flag raised when the watchdog abandons an EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wd_fire) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign exec_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: SET_EN and zero-mask EXEC complete without leaving IDLE.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op_e)
            OP_RESTART, OP_DIV_SYNC: state_d = S_PULSE;
            OP_EXEC: begin
              if (|cmd_mask) begin
                state_d = S_EXEC_WAIT;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_PULSE:     state_d = S_IDLE;
      S_EXEC_WAIT: begin
        if (consume || wd_fire) begin
          state_d = S_EXEC_DONE;
        end
      end
      S_EXEC_DONE: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Command latch, captured on the accept edge and held for the whole command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_SET_EN;
      mask_q <= '0;
      tgt_q  <= '0;
      data_q <= 16'h0000;
    end else if (accept) begin
      op_q   <= cmd_op_e;
      mask_q <= cmd_mask;
      tgt_q  <= cmd_lowest;
      data_q <= cmd_data;
    end
  end

  // Enable register: SET_EN merges under the mask, RESTART clears the restarted machines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= '0;
    end else if (accept) begin
      case (cmd_op_e)
        OP_SET_EN:  en <= (cmd_data[NUM_SM-1:0] & cmd_mask) | (en & ~cmd_mask);
        OP_RESTART: en <= en & ~cmd_mask;
        default:    en <= en;
      endcase
    end
  end

  // Pulses and the immediate instruction are decoded from state so reset removes them at once.
  assign restart     = (state == S_PULSE && op_q == OP_RESTART)  ? mask_q : '0;
  assign div_restart = (state == S_PULSE && op_q == OP_DIV_SYNC) ? mask_q : '0;
  assign imm         = (state == S_EXEC_WAIT) ? tgt_q  : '0;
  assign imm_instr   = (state == S_EXEC_WAIT) ? data_q : 16'h0000;

endmodule
